// File: rtl/rominit_mux.sv
// rominit_mux: packs a host download byte stream into little-endian words and
// writes them, with an auto-incrementing word address, to one one-hot selected region.
module rominit_mux #(
    parameter int unsigned NUM_REGIONS = 3,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned WORD_BYTES  = 1
) (
    input  logic                    CLK,
    input  logic                    RESB,
    input  logic [NUM_REGIONS-1:0]  SEL,
    input  logic [7:0]              IN_DATA,
    input  logic                    IN_LAST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [NUM_REGIONS-1:0]  OUT_SEL,
    output logic [ADDR_W-1:0]       OUT_ADDR,
    output logic [8*WORD_BYTES-1:0] OUT_DATA,
    output logic [WORD_BYTES-1:0]   OUT_BE,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    BUSY,
    output logic [NUM_REGIONS-1:0]  DONE,
    output logic                    ERR
);
    localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [NUM_REGIONS-1:0]  sel_q, sel_d;
    logic [NUM_REGIONS-1:0]  done_q, done_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [8*WORD_BYTES-1:0] data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic                    sel_onehot;
    logic                    in_fire;
    logic [8*WORD_BYTES-1:0] first_word;

    assign sel_onehot = (SEL != '0) && ((SEL & (SEL - NUM_REGIONS'(1))) == '0);
    assign first_word = (8*WORD_BYTES)'(IN_DATA);

    // In EMIT a new byte may only enter when the current word leaves this cycle,
    // which keeps one byte per cycle without a skid buffer.
    assign IN_READY = RESB && ((state_q != EMIT) || (OUT_READY && !last_q));
    assign in_fire  = IN_VALID && IN_READY;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (sel_onehot) begin
                        sel_d   = SEL;
                        done_d  = done_q & ~SEL;
                        addr_d  = '0;
                        data_d  = first_word;
                        cnt_d   = CNT_W'(1);
                        last_d  = IN_LAST;
                        state_d = (WORD_BYTES == 1 || IN_LAST) ? EMIT : FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (in_fire) begin
                    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                        if (cnt_q == CNT_W'(i)) data_d[8*i +: 8] = IN_DATA;
                    end
                    cnt_d  = cnt_q + CNT_W'(1);
                    last_d = IN_LAST;
                    if (cnt_d == FULL || IN_LAST) state_d = EMIT;
                end
            end
            EMIT: begin
                if (OUT_READY) begin
                    if (last_q) begin
                        done_d  = done_q | sel_q;
                        sel_d   = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else if (addr_q == '1) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = DRAIN;
                        // The byte taken alongside the overflowing word may already end the image.
                        if (in_fire && IN_LAST) begin
                            sel_d   = '0;
                            addr_d  = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (in_fire) begin
                            data_d  = first_word;
                            cnt_d   = CNT_W'(1);
                            last_d  = IN_LAST;
                            state_d = (WORD_BYTES == 1 || IN_LAST) ? EMIT : FILL;
                        end else begin
                            data_d  = '0;
                            cnt_d   = '0;
                            state_d = FILL;
                        end
                    end
                end
            end
            DRAIN: begin
                if (in_fire && IN_LAST) begin
                    sel_d   = '0;
                    addr_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_q <= IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        OUT_BE = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            OUT_BE[i] = (state_q == EMIT) && (CNT_W'(i) < cnt_q);
        end
    end

    assign OUT_VALID = (state_q == EMIT);
    assign OUT_SEL   = sel_q;
    assign OUT_ADDR  = addr_q;
    assign OUT_DATA  = data_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule
